// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Purpose  : Instruction-fetch front end. Issues word fetches over a req/ack
//            handshake, buffers {pc+4, instr} in a small FIFO for decode and
//            flushes/restarts on a branch or jump redirect.
// Revision : 1.0  initial release
// ============================================================================
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic                       imem_req_o,
    output logic [31:0]                imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [31:0]                imem_data_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    input  logic                       stall_i,
    output logic                       instr_valid_o,
    output logic [31:0]                instr_o,
    output logic [31:0]                pc_plus4_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int          PW         = $clog2(DEPTH);
    localparam int          CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [31:0] C_WORD_MSK = 32'hFFFF_FFFC;
    localparam logic [31:0] C_RST_PC   = RESET_PC & C_WORD_MSK;

    logic [31:0]   r_fetch_pc;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pc4   [DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_req;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_next_pc;

    assign w_full    = (r_count == C_DEPTH);
    assign w_empty   = (r_count == '0);
    // Full blocks the request even when a pop happens in the same cycle.
    assign w_req     = !rst_i && !redirect_i && !w_full;
    assign w_push    = w_req && imem_ack_i;
    assign w_pop     = !w_empty && !stall_i && !redirect_i;
    assign w_next_pc = r_fetch_pc + 32'd4;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fetch_pc <= C_RST_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_pc4[i]   <= '0;
            end
        end else if (redirect_i) begin
            r_fetch_pc <= redirect_pc_i & C_WORD_MSK;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_instr[r_wr_ptr] <= imem_data_i;
                r_pc4[r_wr_ptr]   <= w_next_pc;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
                r_fetch_pc        <= w_next_pc;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_fetch_pc;
    assign instr_valid_o = !w_empty;
    assign instr_o       = r_instr[r_rd_ptr];
    assign pc_plus4_o    = r_pc4[r_rd_ptr];
    assign count_o       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Purpose  : Self-checking bench: directed vector table, hand-written corner
//            sequences and randomized traffic against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch_queue;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic        redir;
    logic [31:0] rpc;
    logic        stall;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [2:0]  count;

    int n_pass  = 0;
    int n_total = 0;

    if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_ack_i    (ack),
        .imem_data_i   (data),
        .redirect_i    (redir),
        .redirect_pc_i (rpc),
        .stall_i       (stall),
        .instr_valid_o (valid),
        .instr_o       (instr),
        .pc_plus4_o    (pc4),
        .count_o       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        if (a == 32'h0) return 32'h2002_0005;
        if (a == 32'h4) return 32'h2003_0007;
        return {a[31:16] ^ a[15:0] ^ 16'h1357, a[15:0] ^ 16'h0F0F};
    endfunction

    // Instruction memory: the word at the presented address is always on the bus.
    assign data = word_of(addr);

    // Reference model: an ordered queue of {pc+4, instr} plus the fetch PC.
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_fpc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_update();
        bit do_pop;
        bit do_push;
        if (redir) begin
            mq.delete();
            m_fpc = rpc & 32'hFFFF_FFFC;
        end else begin
            do_pop  = (mq.size() != 0) && !stall;
            do_push = (mq.size() < 4) && ack;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back('{pc4: m_fpc + 32'd4, instr: word_of(m_fpc)});
                m_fpc = m_fpc + 32'd4;
            end
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, "_req"},   {31'b0, req},   {31'b0, !redir && (mq.size() < 4)});
        chk({tag, "_addr"},  addr,           m_fpc);
        chk({tag, "_count"}, {29'b0, count}, 32'(mq.size()));
        chk({tag, "_valid"}, {31'b0, valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk({tag, "_instr"}, instr, mq[0].instr);
            chk({tag, "_pc4"},   pc4,   mq[0].pc4);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'b0, req},   32'h0);
        chk({tag, "_addr"},  addr,           32'h0);
        chk({tag, "_valid"}, {31'b0, valid}, 32'h0);
        chk({tag, "_instr"}, instr,          32'h0);
        chk({tag, "_pc4"},   pc4,            32'h0);
        chk({tag, "_count"}, {29'b0, count}, 32'h0);
    endtask

    typedef struct {
        logic        ack;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [2:0]  count;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic a, input logic s, input logic r, input logic [31:0] p,
                       input logic e_req, input logic [31:0] e_addr, input logic e_val,
                       input logic [31:0] e_ins, input logic [31:0] e_pc4, input logic [2:0] e_cnt);
        vecs.push_back('{a, s, r, p, e_req, e_addr, e_val, e_ins, e_pc4, e_cnt});
    endtask

    initial begin
        logic [31:0] w0;
        logic [31:0] w4;
        w0 = 32'h2002_0005;
        w4 = 32'h2003_0007;

        rst = 1'b1; ack = 1'b0; redir = 1'b0; rpc = '0; stall = 1'b0;
        mq.delete();
        m_fpc = 32'h0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // ack stall redir rpc | req addr valid instr pc4 count
        add(1,0,0,0,            1, 32'd0,  0, 0, 0, 0);               // first fetch
        add(1,0,0,0,            1, 32'd4,  1, w0, 32'd4, 1);          // valid one cycle after ack
        add(0,1,1,0,            0, 32'd8,  1, w4, 32'd8, 1);          // redirect to 0
        add(1,1,0,0,            1, 32'd0,  0, 0, 0, 0);
        add(1,1,0,0,            1, 32'd4,  1, w0, 32'd4, 1);
        add(1,1,0,0,            1, 32'd8,  1, w0, 32'd4, 2);
        add(1,1,0,0,            1, 32'd12, 1, w0, 32'd4, 3);
        add(1,1,0,0,            0, 32'd16, 1, w0, 32'd4, 4);          // full, ack ignored
        add(1,0,0,0,            0, 32'd16, 1, w0, 32'd4, 4);          // full + pop: still no req
        add(0,0,0,0,            1, 32'd16, 1, w4, 32'd8, 3);
        add(0,0,0,0,            1, 32'd16, 1, word_of(32'd8),  32'd12, 2);
        add(0,0,0,0,            1, 32'd16, 1, word_of(32'd12), 32'd16, 1);
        add(0,0,0,0,            1, 32'd16, 0, 0, 0, 0);
        add(1,1,0,0,            1, 32'd16, 0, 0, 0, 0);
        add(1,1,0,0,            1, 32'd20, 1, word_of(32'd16), 32'd20, 1);
        add(1,1,0,0,            1, 32'd24, 1, word_of(32'd16), 32'd20, 2);
        add(1,0,1,32'h43,       0, 32'd28, 1, word_of(32'd16), 32'd20, 3); // redirect beats ack and pop
        add(0,0,0,0,            1, 32'h40, 0, 0, 0, 0);
        add(1,0,1,32'hFFFF_FFFC,0, 32'h40, 0, 0, 0, 0);
        add(1,1,0,0,            1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        add(1,1,0,0,            1, 32'd0,  1, word_of(32'hFFFF_FFFC), 32'd0, 1); // pc+4 wraps
        add(1,0,0,0,            1, 32'd4,  1, word_of(32'hFFFF_FFFC), 32'd0, 2); // push+pop
        add(0,0,0,0,            1, 32'd8,  1, w0, 32'd4, 2);
        add(0,0,0,0,            1, 32'd8,  1, w4, 32'd8, 1);
        add(0,0,0,0,            1, 32'd8,  0, 0, 0, 0);
        add(0,0,1,32'd100,      0, 32'd8,  0, 0, 0, 0);
        add(0,0,1,32'd200,      0, 32'd100,0, 0, 0, 0);               // last redirect wins
        add(0,0,0,0,            1, 32'd200,0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            ack = vecs[i].ack; stall = vecs[i].stall; redir = vecs[i].redir; rpc = vecs[i].rpc;
            @(negedge clk);
            chk($sformatf("vec%0d_req", i),   {31'b0, req},   {31'b0, vecs[i].req});
            chk($sformatf("vec%0d_addr", i),  addr,           vecs[i].addr);
            chk($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].valid});
            chk($sformatf("vec%0d_count", i), {29'b0, count}, {29'b0, vecs[i].count});
            if (vecs[i].valid) begin
                chk($sformatf("vec%0d_instr", i), instr, vecs[i].instr);
                chk($sformatf("vec%0d_pc4", i),   pc4,   vecs[i].pc4);
            end
            tick();
        end

        // Wait states: address held, nothing pushed until the ack arrives.
        ack = 1'b0; stall = 1'b0; redir = 1'b0; rpc = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_req",   {31'b0, req},   32'h1);
            chk("wait_addr",  addr,           32'd200);
            chk("wait_count", {29'b0, count}, 32'h0);
            tick();
        end
        ack = 1'b1;
        @(negedge clk);
        chk("ack_addr", addr, 32'd200);
        tick();
        ack = 1'b0;
        @(negedge clk);
        chk("ack_valid", {31'b0, valid}, 32'h1);
        chk("ack_instr", instr,          word_of(32'd200));
        chk("ack_pc4",   pc4,            32'd204);
        tick();

        // Async reset in the middle of a wait state with entries buffered.
        ack = 1'b1; stall = 1'b1;
        tick();
        tick();
        ack = 1'b0;
        @(negedge clk);
        chk("prerst_count", {29'b0, count}, 32'd2);
        chk("prerst_req",   {31'b0, req},   32'h1);
        #1 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        mq.delete();
        m_fpc = 32'h0;
        stall = 1'b0;
        @(negedge clk);
        model_check("post_rst");
        tick();

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            ack   = ($urandom_range(3) != 0);
            stall = ($urandom_range(2) == 0);
            redir = ($urandom_range(15) == 0);
            rpc   = $urandom;
            @(negedge clk);
            model_check("rand");
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
